mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single cache-to-DDR2/MMIO memory port (28-bit address, 32-bit data, valid/ready handshake) between the I-cache side (client 0) and the D-cache side (client 1). It sits between the caches and the memory controller/SPART decode and serialises one transaction at a time. Grants are round-robin, and a timeout abort returns an error so a hung slave cannot lock out both caches.

## Interface
- ADDR_W, 28, address width on all ports
- DATA_W, 32, data width on all ports
- TIMEOUT, 1023, cycles in BUSY without mem_ready before abort (≥2)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- c0_valid / c1_valid  in  1  request valid; held until matching cN_ready pulse
- c0_rw / c1_rw  in  1  1 = write, 0 = read
- c0_addr / c1_addr  in  ADDR_W  request address
- c0_wdata / c1_wdata  in  DATA_W  write data
- c0_rdata / c1_rdata  out  DATA_W  read data, valid with cN_ready, held until next completion for that client
- c0_ready / c1_ready  out  1  one-cycle completion pulse
- c0_err / c1_err  out  1  one-cycle pulse coincident with cN_ready on timeout abort
- mem_valid  out  1  request to memory side
- mem_rw  out  1  forwarded rw
- mem_addr  out  ADDR_W  forwarded address
- mem_wdata  out  DATA_W  forwarded write data
- mem_rdata  in  DATA_W  response data
- mem_ready  in  1  response; may be level, held until mem_valid drops

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE: if any cN_valid, pick winner, register rw/addr/wdata into mem_* outputs, set mem_valid=1, clear timeout counter → BUSY. No request: outputs unchanged, mem_valid=0.
- Arbitration: a single requester wins. On a tie, the client other than last_grant wins. last_grant resets to 1, so c0 wins the first tie. last_grant updates on every grant.
- BUSY: mem_* held stable. On mem_ready=1: capture mem_rdata into winner's cN_rdata, pulse winner's cN_ready, drop mem_valid and zero mem_rw/mem_addr → DRAIN. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no mem_ready: winner's cN_rdata=32'hDEADBEEF, pulse cN_ready and cN_err, drop mem_valid → DRAIN.
- DRAIN: wait for mem_ready=0, then → IDLE. Both cN_valid are ignored in DRAIN. The winner must have dropped valid on the cycle it sampled cN_ready.
- Reads and writes are treated identically. For writes, cN_rdata is still updated with mem_rdata (don't-care to the client).
- A client dropping valid mid-BUSY is illegal. The transaction still completes and the ready pulse is still issued.
- Reset (any state, including mid-BUSY): state=IDLE, last_grant=1, counter=0. All outputs are 0: mem_valid, mem_rw, mem_addr, mem_wdata, cN_ready, cN_err, cN_rdata. An in-flight transaction is discarded without a response.

## Timing
- cN_valid sampled at edge N → mem_valid high after edge N (visible cycle N+1).
- mem_ready sampled at edge M → cN_ready/cN_rdata high for exactly the cycle after M; mem_valid low the same cycle.
- Minimum turnaround: 1 DRAIN cycle after mem_ready falls. Back-to-back service of the opposite client is therefore ≥1 cycle after DRAIN exits.
- Timeout fires on the TIMEOUT-th BUSY cycle without ready. mem_ready arriving on that same edge takes priority: normal completion, no err.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package mem_arb_pkg: state enum (IDLE/BUSY/DRAIN), ABORT_DATA=32'hDEADBEEF, and the shared MMIO constants SPART_DATA_ADDR=28'h8000000 and SPART_STATUS_ADDR=28'h8000001 (status bit1 = rx ready, bit0 = tx ready).
- Sub-module mem_arb_rr2: combinational 2-way round-robin pick (inputs: req[1:0], last_grant; output: grant index). Everything else lives in the top module.

## Test plan
- Single c1 read of 28'h8000001 with mem_ready after 3 cycles and mem_rdata=32'h2 → mem_valid 1 cycle after request; c1_ready pulses once with c1_rdata=32'h2; c0 outputs untouched.
- c0 and c1 valid on the same cycle after reset → c0 granted first, c1 granted after c0's DRAIN; a second simultaneous pair → c1 wins the tie (last_grant=0).
- c1 write to 28'h8000000 with wdata=32'hA5A5A5A5 → mem_rw=1, mem_addr=28'h8000000, mem_wdata=32'hA5A5A5A5 stable through BUSY.
- mem_ready never asserted with TIMEOUT=8 → after 8 BUSY cycles c0_ready and c0_err pulse together, c0_rdata=32'hDEADBEEF, mem_valid=0.
- mem_ready held high for 5 cycles after completion while c1 requests → no new mem_valid until mem_ready drops; c1 is then served.
- rst asserted mid-BUSY → next cycle all outputs 0; no ready pulse; a subsequent c0 request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-side memory port arbiter.
// Also carries the MMIO addresses the caches and SPART decode agree on.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    // SPART status word: bit1 = rx ready, bit0 = tx ready
    localparam logic [27:0] SPART_DATA_ADDR    = 28'h8000000;
    localparam logic [27:0] SPART_STATUS_ADDR  = 28'h8000001;
    localparam int          SPART_RX_READY_BIT = 1;
    localparam int          SPART_TX_READY_BIT = 0;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// client that was not granted last.
module mem_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = last_grant;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-cache (client 0) and D-cache (client 1) requests onto the
// single memory port, with a timeout abort so a hung slave cannot lock both out.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_valid,
    input  logic              c0_rw,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_ready,
    output logic              c0_err,
    input  logic              c1_valid,
    input  logic              c1_rw,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_ready,
    output logic              c1_err,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic              r_winner;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_grant;
    logic              w_start;
    logic              w_done;
    logic              w_abort;

    logic              r_mem_valid;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata [2];
    logic [1:0]        r_ready;
    logic [1:0]        r_err;

    mem_arb_rr2 u_rr2 (
        .req        ({c1_valid, c0_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (c0_valid || c1_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A response on the final timeout cycle still completes normally
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!mem_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_winner     <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
            r_ready     <= '0;
            r_err       <= '0;
        end else begin
            r_ready <= '0;
            r_err   <= '0;
            if (w_start) begin
                r_mem_valid <= 1'b1;
                r_mem_rw    <= w_grant ? c1_rw    : c0_rw;
                r_mem_addr  <= w_grant ? c1_addr  : c0_addr;
                r_mem_wdata <= w_grant ? c1_wdata : c0_wdata;
            end
            if (w_done) begin
                r_rdata[r_winner] <= mem_rdata;
                r_ready[r_winner] <= 1'b1;
                r_mem_valid       <= 1'b0;
                r_mem_rw          <= 1'b0;
                r_mem_addr        <= '0;
            end
            if (w_abort) begin
                r_rdata[r_winner] <= DATA_W'(ABORT_DATA);
                r_ready[r_winner] <= 1'b1;
                r_err[r_winner]   <= 1'b1;
                r_mem_valid       <= 1'b0;
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign c0_rdata  = r_rdata[0];
    assign c1_rdata  = r_rdata[1];
    assign c0_ready  = r_ready[0];
    assign c1_ready  = r_ready[1];
    assign c0_err    = r_err[0];
    assign c1_err    = r_err[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=8: arbitration order,
// write forwarding, timeout abort, held mem_ready and mid-transaction reset.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_valid, c0_rw, c1_valid, c1_rw;
    logic [27:0] c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic [31:0] c0_rdata, c1_rdata;
    logic        c0_ready, c0_err, c1_ready, c1_err;
    logic        mem_valid, mem_rw, mem_ready;
    logic [27:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(28), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .c0_valid(c0_valid), .c0_rw(c0_rw), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_rdata(c0_rdata), .c0_ready(c0_ready), .c0_err(c0_err),
        .c1_valid(c1_valid), .c1_rw(c1_rw), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_ready(c1_ready), .c1_err(c1_err),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        c0_valid = 0; c0_rw = 0; c0_addr = '0; c0_wdata = '0;
        c1_valid = 0; c1_rw = 0; c1_addr = '0; c1_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 28'h0);
        chk("rst_c0_ready", c0_ready, 1'b0);
        chk("rst_c1_rdata", c1_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // single c1 read of SPART status, response after 3 cycles
        c1_valid = 1; c1_rw = 0; c1_addr = SPART_STATUS_ADDR;
        tick();
        chk("rd_mem_valid", mem_valid, 1'b1);
        chk("rd_mem_addr", mem_addr, SPART_STATUS_ADDR);
        chk("rd_mem_rw", mem_rw, 1'b0);
        tick(); tick();
        chk("rd_no_early_ready", c1_ready, 1'b0);
        mem_ready = 1; mem_rdata = 32'h2;
        tick();
        chk("rd_c1_ready", c1_ready, 1'b1);
        chk("rd_c1_rdata", c1_rdata, 32'h2);
        chk("rd_mem_valid_drop", mem_valid, 1'b0);
        chk("rd_mem_addr_zero", mem_addr, 28'h0);
        chk("rd_c0_ready", c0_ready, 1'b0);
        chk("rd_c0_rdata", c0_rdata, 32'h0);
        c1_valid = 0; mem_ready = 0;
        tick();
        chk("rd_c1_ready_pulse", c1_ready, 1'b0);
        chk("rd_c1_rdata_hold", c1_rdata, 32'h2);
        tick();

        // simultaneous requests after reset: c0, then c1, then c1 wins re-tie
        rst = 1; tick(); rst = 0;
        c0_valid = 1; c0_addr = 28'h0000100; c1_valid = 1; c1_addr = 28'h0000200;
        tick();
        chk("tie1_addr_c0", mem_addr, 28'h0000100);
        mem_ready = 1; mem_rdata = 32'h11111111;
        tick();
        chk("tie1_c0_ready", c0_ready, 1'b1);
        chk("tie1_c0_rdata", c0_rdata, 32'h11111111);
        chk("tie1_c1_ready", c1_ready, 1'b0);
        c0_valid = 0; mem_ready = 0;
        tick();
        chk("tie1_drain_idle", mem_valid, 1'b0);
        c0_valid = 1; c0_addr = 28'h0000300;
        tick();
        chk("tie2_addr_c1", mem_addr, 28'h0000200);
        mem_ready = 1; mem_rdata = 32'h22222222;
        tick();
        chk("tie2_c1_ready", c1_ready, 1'b1);
        chk("tie2_c1_rdata", c1_rdata, 32'h22222222);
        c1_valid = 0; mem_ready = 0;
        tick(); tick();
        chk("tie3_addr_c0", mem_addr, 28'h0000300);
        mem_ready = 1; mem_rdata = 32'h33333333;
        tick();
        chk("tie3_c0_rdata", c0_rdata, 32'h33333333);
        c0_valid = 0; mem_ready = 0;
        tick(); tick();

        // c1 write to SPART data held stable through BUSY
        c1_valid = 1; c1_rw = 1; c1_addr = SPART_DATA_ADDR; c1_wdata = 32'hA5A5A5A5;
        tick();
        chk("wr_mem_rw", mem_rw, 1'b1);
        chk("wr_mem_addr", mem_addr, SPART_DATA_ADDR);
        chk("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        tick(); tick();
        chk("wr_hold_valid", mem_valid, 1'b1);
        chk("wr_hold_addr", mem_addr, SPART_DATA_ADDR);
        chk("wr_hold_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ready = 1; mem_rdata = 32'h0;
        tick();
        chk("wr_c1_ready", c1_ready, 1'b1);
        chk("wr_rw_zero", mem_rw, 1'b0);
        c1_valid = 0; c1_rw = 0; mem_ready = 0;
        tick(); tick();

        // timeout: no mem_ready for 8 BUSY cycles
        c0_valid = 1; c0_addr = 28'h0000400;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet", c0_ready, 1'b0);
        chk("to_valid_still", mem_valid, 1'b1);
        tick();
        chk("to_c0_ready", c0_ready, 1'b1);
        chk("to_c0_err", c0_err, 1'b1);
        chk("to_c0_rdata", c0_rdata, 32'hDEADBEEF);
        chk("to_mem_valid", mem_valid, 1'b0);
        c0_valid = 0;
        tick();
        chk("to_err_pulse", c0_err, 1'b0);
        tick();

        // mem_ready on the timeout edge takes priority
        c0_valid = 1; c0_addr = 28'h0000480;
        tick();
        for (int i = 0; i < 7; i++) tick();
        mem_ready = 1; mem_rdata = 32'h77;
        tick();
        chk("toedge_ready", c0_ready, 1'b1);
        chk("toedge_no_err", c0_err, 1'b0);
        chk("toedge_rdata", c0_rdata, 32'h77);
        c0_valid = 0; mem_ready = 0;
        tick(); tick();

        // mem_ready held after completion blocks the next grant
        c0_valid = 1; c0_addr = 28'h0000500;
        tick();
        mem_ready = 1; mem_rdata = 32'h55;
        tick();
        chk("hold_c0_ready", c0_ready, 1'b1);
        c0_valid = 0; c1_valid = 1; c1_addr = 28'h0000600;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_no_valid", mem_valid, 1'b0);
        end
        mem_ready = 0;
        tick();
        chk("hold_drain_exit", mem_valid, 1'b0);
        tick();
        chk("hold_c1_valid", mem_valid, 1'b1);
        chk("hold_c1_addr", mem_addr, 28'h0000600);
        mem_ready = 1; mem_rdata = 32'h66;
        tick();
        chk("hold_c1_rdata", c1_rdata, 32'h66);
        c1_valid = 0; mem_ready = 0;
        tick(); tick();

        // reset mid-BUSY discards the transaction
        c0_valid = 1; c0_addr = 28'h0000700;
        tick(); tick();
        rst = 1;
        tick();
        chk("mrst_mem_valid", mem_valid, 1'b0);
        chk("mrst_mem_addr", mem_addr, 28'h0);
        chk("mrst_c0_ready", c0_ready, 1'b0);
        chk("mrst_c0_rdata", c0_rdata, 32'h0);
        chk("mrst_c1_rdata", c1_rdata, 32'h0);
        rst = 0;
        tick();
        chk("mrst_regrant", mem_valid, 1'b1);
        chk("mrst_regrant_addr", mem_addr, 28'h0000700);
        mem_ready = 1; mem_rdata = 32'h99;
        tick();
        chk("mrst_c0_ready", c0_ready, 1'b1);
        chk("mrst_c0_rdata_new", c0_rdata, 32'h99);
        chk("mrst_c0_err", c0_err, 1'b0);
        c0_valid = 0; mem_ready = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
